// File: rtl/rr_arbiter_8_if.sv
// Request/grant bundle shared by the 8-way round-robin arbiter and its requesters.
// master = requester side, slave = arbiter side.
interface rr_arbiter_8_if;
   logic [7:0] req;
   logic       done;
   logic [7:0] gnt;
   logic [2:0] gnt_idx;
   logic       gnt_vld;
   logic       timeout;

   modport master (
      output req,
      output done,
      input  gnt,
      input  gnt_idx,
      input  gnt_vld,
      input  timeout
   );

   modport slave (
      input  req,
      input  done,
      output gnt,
      output gnt_idx,
      output gnt_vld,
      output timeout
   );
endinterface

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters with hold limit and break-before-make.
// Grant is registered as one-hot plus index/enable for a 3-to-8 decoder.
module rr_arbiter_8 #(
   parameter int HOLD_MAX = 16,
   parameter int CNT_W    = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   rr_arbiter_8_if.slave    bus
);

   typedef enum logic {IDLE, GRANT} state_t;

   localparam logic [CNT_W-1:0] HOLD_LAST = (HOLD_MAX == 0) ? '0 : CNT_W'(HOLD_MAX - 1);
   localparam logic [CNT_W-1:0] CNT_SAT   = '1;

   state_t           state;
   logic [2:0]       ptr;
   logic [CNT_W-1:0] cnt;
   logic [7:0]       gnt_q;
   logic [2:0]       gnt_idx_q;
   logic             gnt_vld_q;
   logic             timeout_q;

   logic             found;
   logic [2:0]       win;
   logic             rel_done;
   logic             rel_drop;
   logic             rel_hold;

   // Circular search starting at ptr; the first requester found wins.
   always_comb begin
      logic [2:0] idx;
      found = 1'b0;
      win   = ptr;
      idx   = ptr;
      for (int k = 0; k < 8; k++) begin
         idx = ptr + 3'(k);
         if (!found && bus.req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   assign rel_done = bus.done;
   assign rel_drop = !bus.req[gnt_idx_q];
   assign rel_hold = (HOLD_MAX != 0) && (cnt == HOLD_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= 3'd0;
         cnt       <= '0;
         gnt_q     <= 8'd0;
         gnt_idx_q <= 3'd0;
         gnt_vld_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= 1'b0;
         case (state)
            IDLE: begin
               if (found) begin
                  state     <= GRANT;
                  gnt_q     <= 8'd1 << win;
                  gnt_idx_q <= win;
                  gnt_vld_q <= 1'b1;
                  ptr       <= win + 3'd1;
                  cnt       <= '0;
               end
            end
            GRANT: begin
               if (rel_done || rel_drop || rel_hold) begin
                  state     <= IDLE;
                  gnt_q     <= 8'd0;
                  gnt_idx_q <= 3'd0;
                  gnt_vld_q <= 1'b0;
                  cnt       <= '0;
                  // Only flag a revocation the owner did not ask for.
                  timeout_q <= rel_hold && !rel_done && !rel_drop;
               end else if (cnt != CNT_SAT) begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.gnt_idx = gnt_idx_q;
   assign bus.gnt_vld = gnt_vld_q;
   assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed bench for rr_arbiter_8 (HOLD_MAX=4): each step queues its expected
// outputs, which are popped and compared one clock later.
module tb_rr_arbiter_8;

   logic clk;
   logic rst_n;

   rr_arbiter_8_if bus ();

   rr_arbiter_8 #(.HOLD_MAX(4), .CNT_W(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   typedef struct {
      logic [7:0] gnt;
      logic       timeout;
      string      tag;
   } exp_t;

   exp_t sb[$];
   int   vectors     = 0;
   int   miscompares = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [2:0] onehot_idx(input logic [7:0] v);
      logic [2:0] r;
      r = 3'd0;
      for (int i = 0; i < 8; i++)
         if (v[i]) r = 3'(i);
      return r;
   endfunction

   task automatic check_output();
      exp_t       e;
      logic [2:0] e_idx;
      logic       e_vld;
      if (sb.size() == 0) begin
         vectors++;
         miscompares++;
         $error("[TB] FAIL scoreboard_empty: observed 0 entries, expected at least 1");
         return;
      end
      e     = sb.pop_front();
      e_vld = (e.gnt != 8'd0);
      e_idx = onehot_idx(e.gnt);

      vectors++;
      assert (bus.gnt === e.gnt) else begin
         miscompares++;
         $error("[TB] FAIL %s gnt: observed %h expected %h", e.tag, bus.gnt, e.gnt);
      end
      vectors++;
      assert (bus.gnt_idx === e_idx) else begin
         miscompares++;
         $error("[TB] FAIL %s gnt_idx: observed %0d expected %0d", e.tag, bus.gnt_idx, e_idx);
      end
      vectors++;
      assert (bus.gnt_vld === e_vld) else begin
         miscompares++;
         $error("[TB] FAIL %s gnt_vld: observed %b expected %b", e.tag, bus.gnt_vld, e_vld);
      end
      vectors++;
      assert (bus.timeout === e.timeout) else begin
         miscompares++;
         $error("[TB] FAIL %s timeout: observed %b expected %b", e.tag, bus.timeout, e.timeout);
      end
      vectors++;
      assert (bus.gnt === (bus.gnt_vld ? (8'd1 << bus.gnt_idx) : 8'd0)) else begin
         miscompares++;
         $error("[TB] FAIL %s gnt_consistency: observed %h expected %h", e.tag, bus.gnt,
                bus.gnt_vld ? (8'd1 << bus.gnt_idx) : 8'd0);
      end
   endtask

   // Drive one cycle of inputs and queue the outputs expected after the next edge.
   task automatic apply_stimulus(input logic rst_v, input logic [7:0] req_v,
                                 input logic done_v, input logic [7:0] exp_gnt,
                                 input logic exp_to, input string tag);
      exp_t e;
      @(negedge clk);
      rst_n    = rst_v;
      bus.req  = req_v;
      bus.done = done_v;
      e.gnt     = exp_gnt;
      e.timeout = exp_to;
      e.tag     = tag;
      sb.push_back(e);
      @(posedge clk);
      #1;
      check_output();
   endtask

   initial begin
      rst_n    = 1'b0;
      bus.req  = 8'd0;
      bus.done = 1'b0;

      // Reset, then a single requester released by done on its 3rd grant cycle.
      apply_stimulus(1'b0, 8'h04, 1'b0, 8'h00, 1'b0, "reset0");
      apply_stimulus(1'b0, 8'h04, 1'b0, 8'h00, 1'b0, "reset1");
      apply_stimulus(1'b1, 8'h04, 1'b0, 8'h04, 1'b0, "single_first");
      apply_stimulus(1'b1, 8'h04, 1'b0, 8'h04, 1'b0, "single_hold1");
      apply_stimulus(1'b1, 8'h04, 1'b0, 8'h04, 1'b0, "single_hold2");
      apply_stimulus(1'b1, 8'h04, 1'b1, 8'h00, 1'b0, "single_done");
      apply_stimulus(1'b1, 8'h04, 1'b0, 8'h04, 1'b0, "single_regrant");
      apply_stimulus(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, "single_drop");
      apply_stimulus(1'b1, 8'h00, 1'b1, 8'h00, 1'b0, "idle_done_ignored");

      // Full round robin from ptr=0 with a one-cycle gap between owners.
      apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, "rr_reset");
      for (int i = 0; i < 9; i++) begin
         apply_stimulus(1'b1, 8'hFF, 1'b0, 8'd1 << (i % 8), 1'b0, $sformatf("rr_grant%0d", i));
         apply_stimulus(1'b1, 8'hFF, 1'b1, 8'h00, 1'b0, $sformatf("rr_gap%0d", i));
      end

      // Park ptr at 6 via a grant to 5, then check wrap order 0 then 1.
      apply_stimulus(1'b1, 8'h20, 1'b0, 8'h20, 1'b0, "wrap_setup");
      apply_stimulus(1'b1, 8'h20, 1'b1, 8'h00, 1'b0, "wrap_setup_rel");
      apply_stimulus(1'b1, 8'h03, 1'b0, 8'h01, 1'b0, "wrap_idx0");
      apply_stimulus(1'b1, 8'h03, 1'b1, 8'h00, 1'b0, "wrap_rel0");
      apply_stimulus(1'b1, 8'h03, 1'b0, 8'h02, 1'b0, "wrap_idx1");
      apply_stimulus(1'b1, 8'h03, 1'b1, 8'h00, 1'b0, "wrap_rel1");

      // Hold limit: visible for exactly 4 cycles, one-cycle timeout pulse, re-grant.
      for (int i = 0; i < 4; i++)
         apply_stimulus(1'b1, 8'h80, 1'b0, 8'h80, 1'b0, $sformatf("to_hold%0d", i));
      apply_stimulus(1'b1, 8'h80, 1'b0, 8'h00, 1'b1, "to_pulse");
      apply_stimulus(1'b1, 8'h80, 1'b0, 8'h80, 1'b0, "to_regrant");
      apply_stimulus(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, "to_drop");

      // Request drop mid-grant.
      apply_stimulus(1'b1, 8'h08, 1'b0, 8'h08, 1'b0, "drop_grant");
      apply_stimulus(1'b1, 8'h08, 1'b0, 8'h08, 1'b0, "drop_hold");
      apply_stimulus(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, "drop_rel");

      // done coinciding with the hold limit suppresses timeout.
      for (int i = 0; i < 4; i++)
         apply_stimulus(1'b1, 8'h08, 1'b0, 8'h08, 1'b0, $sformatf("cd_hold%0d", i));
      apply_stimulus(1'b1, 8'h08, 1'b1, 8'h00, 1'b0, "cd_done_at_limit");

      // Request drop coinciding with the hold limit suppresses timeout.
      for (int i = 0; i < 4; i++)
         apply_stimulus(1'b1, 8'h08, 1'b0, 8'h08, 1'b0, $sformatf("cr_hold%0d", i));
      apply_stimulus(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, "cr_drop_at_limit");

      // Reset mid-grant of index 5; afterwards the search restarts at 0.
      apply_stimulus(1'b1, 8'h20, 1'b0, 8'h20, 1'b0, "rst_grant5");
      apply_stimulus(1'b1, 8'h20, 1'b0, 8'h20, 1'b0, "rst_hold5");
      apply_stimulus(1'b0, 8'h60, 1'b0, 8'h00, 1'b0, "rst_midgrant");
      apply_stimulus(1'b1, 8'h60, 1'b0, 8'h20, 1'b0, "rst_ptr0");
      apply_stimulus(1'b1, 8'h60, 1'b1, 8'h00, 1'b0, "rst_rel");
      apply_stimulus(1'b1, 8'h60, 1'b0, 8'h40, 1'b0, "rst_next6");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: observed no completion by 100000, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
